// File: rtl/phf_cmds_multi.sv
// Multi-channel PHF command handler: decodes target commands, runs a masked clear handshake
// on up to 16 channels with an optional timeout, and returns one response per command.

// Fallback command-word layout; a shared cmd_defs.vh included earlier takes precedence.
`ifndef CMD_TARGET
`define CMD_TARGET(c) c[31:28]
`endif
`ifndef CMD_INSTR
`define CMD_INSTR(c) c[27:20]
`endif
`ifndef SET_CMD_ERR
`define SET_CMD_ERR(c) ((c) | 32'h0008_0000)
`endif
`ifndef C_TARGET_PHF
`define C_TARGET_PHF 4'h5
`endif
`ifndef C_PHF_CLEAR
`define C_PHF_CLEAR 8'h01
`endif
`ifndef C_PHF_GET_STATUS
`define C_PHF_GET_STATUS 8'h02
`endif
`ifndef C_PHF_GET_BUSY
`define C_PHF_GET_BUSY 8'h03
`endif

module phf_cmds_multi #(
    parameter int unsigned NCH          = 4,
    parameter logic [3:0]  TARGET       = `C_TARGET_PHF,
    parameter logic [7:0]  I_CLEAR      = `C_PHF_CLEAR,
    parameter logic [7:0]  I_GET_STATUS = `C_PHF_GET_STATUS,
    parameter logic [7:0]  I_GET_BUSY   = `C_PHF_GET_BUSY,
    parameter int unsigned TMO          = 1024
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           run,
    input  logic [31:0]    cmd,
    input  logic [NCH-1:0] sts,
    input  logic [NCH-1:0] busy,
    output logic           rsp_rdy,
    output logic [31:0]    rsp,
    output logic [NCH-1:0] clear_req
);

    localparam int unsigned    CntW    = (TMO > 0) ? $clog2(TMO + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((TMO == 0) ? 0 : TMO - 1);

    typedef enum logic [1:0] {
        StIdle,
        StParse,
        StClearReq,
        StWait
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     cmd_q, cmd_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     rsp_q, rsp_d;
    logic            rsp_rdy_q, rsp_rdy_d;

    logic [NCH-1:0]  mask;
    logic [15:0]     arg_hi;
    logic            mask_ok;
    logic [7:0]      instr;
    logic [NCH-1:0]  fail;

    assign mask    = cmd_q[NCH-1:0];
    // Argument bits above the channel range must be zero for a legal mask.
    assign arg_hi  = cmd_q[15:0] >> NCH;
    assign mask_ok = (|mask) && (arg_hi == '0);
    assign instr   = `CMD_INSTR(cmd_q);

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        cnt_d     = cnt_q;
        rsp_d     = rsp_q;
        rsp_rdy_d = 1'b0;
        clear_req = '0;
        fail      = '0;

        unique case (state_q)
            StIdle: begin
                if (run && (`CMD_TARGET(cmd) == TARGET)) begin
                    cmd_d   = cmd;
                    state_d = StParse;
                end
            end

            StParse: begin
                if (instr == I_GET_STATUS) begin
                    rsp_d     = {cmd_q[31:16], 16'(sts)};
                    rsp_rdy_d = 1'b1;
                    state_d   = StIdle;
                end else if (instr == I_GET_BUSY) begin
                    rsp_d     = {cmd_q[31:16], 16'(busy)};
                    rsp_rdy_d = 1'b1;
                    state_d   = StIdle;
                end else if ((instr == I_CLEAR) && mask_ok) begin
                    cnt_d   = '0;
                    state_d = StClearReq;
                end else begin
                    rsp_d     = `SET_CMD_ERR(cmd_q);
                    rsp_rdy_d = 1'b1;
                    state_d   = StIdle;
                end
            end

            StClearReq: begin
                clear_req = mask;
                if ((busy & mask) == mask) begin
                    state_d = StWait;
                end else if ((TMO != 0) && (cnt_q == CntLast)) begin
                    fail      = mask & ~busy;
                    rsp_d     = `SET_CMD_ERR({cmd_q[31:16], 16'(fail)});
                    rsp_rdy_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StWait: begin
                if ((busy & mask) == '0) begin
                    rsp_d     = cmd_q;
                    rsp_rdy_d = 1'b1;
                    state_d   = StIdle;
                end else if ((TMO != 0) && (cnt_q == CntLast)) begin
                    fail      = mask & busy;
                    rsp_d     = `SET_CMD_ERR({cmd_q[31:16], 16'(fail)});
                    rsp_rdy_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cmd_q     <= '0;
            cnt_q     <= '0;
            rsp_q     <= '0;
            rsp_rdy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            cnt_q     <= cnt_d;
            rsp_q     <= rsp_d;
            rsp_rdy_q <= rsp_rdy_d;
        end
    end

    assign rsp     = rsp_q;
    assign rsp_rdy = rsp_rdy_q;

endmodule

// File: doc/phf_cmds_multi.md
# phf_cmds_multi

Parametrised command handler for the PHF target that controls NCH clear/status channels instead of one. It sits on the command bus next to the other per-target handlers, decodes commands addressed to its target and runs a clear handshake on any subset of channels. It reports status and busy vectors and returns one response per command. Compared with the single-channel handler, it adds a channel mask, latched commands, a response sent on completion, and a busy-handshake timeout that carries a failure mask.

## Interface
- NCH, 4: number of channels; legal range 1..16.
- TARGET, `C_TARGET_PHF: target code accepted via `CMD_TARGET(cmd).
- I_CLEAR, `C_PHF_CLEAR: instruction code for masked clear.
- I_GET_STATUS, `C_PHF_GET_STATUS: instruction code for status vector read.
- I_GET_BUSY, `C_PHF_GET_BUSY: instruction code for busy vector read. This code is added to cmd_defs.vh with this block.
- TMO, 1024: clear handshake timeout in cycles; 0 disables the timeout.

- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- run  in  1  command strobe; sampled only in S_IDLE.
- cmd  in  32  command word; latched internally on accept.
- sts  in  NCH  per-channel status.
- busy  in  NCH  per-channel busy from the clear engines.
- rsp_rdy  out  1  one-cycle response-valid pulse.
- rsp  out  32  response word; holds its value until the next response.
- clear_req  out  NCH  per-channel clear request.

## Operation
- Command accept:
  - In S_IDLE, `run && CMD_TARGET(cmd)==TARGET` latches cmd into cmd_q and moves to S_PARSE.
  - In all other states run is ignored and no response is generated.
- Mask: mask = cmd_q[NCH-1:0]. It is illegal if it is zero or if any of cmd_q[15:NCH] is nonzero.
- S_PARSE, decoded on `CMD_INSTR(cmd_q)`:
  - I_GET_STATUS: rsp = {cmd_q[31:16], zero-extended sts sampled this cycle}; rsp_rdy=1; next state S_IDLE.
  - I_GET_BUSY: same as I_GET_STATUS, but with busy instead of sts.
  - I_CLEAR with a legal mask: timeout counter reset to 0; next state S_CLEAR_REQ.
  - I_CLEAR with an illegal mask: rsp = `SET_CMD_ERR(cmd_q); rsp_rdy=1; next state S_IDLE.
  - Any other instruction: same response as I_CLEAR with an illegal mask.
- S_CLEAR_REQ:
  - clear_req = mask. Combinational from state and mask; 0 in every other state.
  - Exit condition: (busy & mask)==mask, then next state S_WAIT.
- S_WAIT:
  - Exit condition: (busy & mask)==0, then rsp = cmd_q; rsp_rdy=1; next state S_IDLE.
- Timeout (TMO>0), evaluated each cycle in S_CLEAR_REQ and S_WAIT:
  - If the exit condition is true, take the transition; success wins over timeout.
  - Else if cnt==TMO-1, time out:
    - In S_CLEAR_REQ, fail = mask & ~busy.
    - In S_WAIT, fail = mask & busy.
    - rsp = `SET_CMD_ERR({cmd_q[31:16], zero-extended fail}); rsp_rdy=1; next state S_IDLE.
  - Else cnt++.
  - cnt width is $clog2(TMO+1).
- With TMO=0 the handler waits indefinitely in S_CLEAR_REQ and S_WAIT.

## Timing
- Reset values: fsm=S_IDLE, rsp_rdy=0, rsp=0, clear_req=0, cnt=0, cmd_q=0.
- Reset behaviour:
  - Reset has priority over run.
  - Reset asserted mid-handshake drops clear_req in the cycle after the reset edge.
  - A command aborted by reset produces no response.
- Read latency: run at cycle t, S_PARSE at t+1, rsp_rdy high at t+2 with rsp valid, back in S_IDLE at t+2.
- Read back-to-back: a new run is accepted at t+2, so one command can be taken every 2 cycles.
- Clear latency:
  - clear_req rises at t+2 and stays high while in S_CLEAR_REQ, at least 1 cycle.
  - If busy is already all-high at t+2, the next state is S_WAIT at t+3.
  - rsp_rdy is high on the first cycle back in S_IDLE.
- The timeout bounds total cycles in S_CLEAR_REQ plus S_WAIT to TMO.
- rsp_rdy is never high for more than one consecutive cycle.
- After cmd is latched, cmd may change with no effect on the command in progress.

## Test plan
- Status read (NCH=4, TMO=16): sts=4'b1010, run with a GET_STATUS cmd at t → rsp_rdy at t+2 only; rsp[15:0]=16'h000A; rsp[31:16]=cmd[31:16].
- Masked clear: CLEAR with mask 4'b0101; bench raises busy[0] and busy[2] 3 cycles after clear_req and drops them 5 cycles later; cmd changed after accept →
  - clear_req=4'b0101 until busy is all-high;
  - one rsp_rdy pulse with rsp equal to the original cmd.
- Timeout in S_CLEAR_REQ: mask 4'b0011 and only busy[0] ever rises → rsp_rdy exactly 16 cycles after entering S_CLEAR_REQ; rsp = `SET_CMD_ERR(cmd with [15:0]=16'h0002).
- Illegal command: mask 0; mask bit 5 set; unknown instruction; other target →
  - first three: error response at t+2, clear_req never asserted;
  - other target: no response.
- Simultaneous events:
  - busy reaches all-high in the cycle where cnt==TMO-1 → success path taken;
  - run pulsed during S_WAIT → ignored.
- Reset at each state of an in-progress clear → outputs return to reset values next cycle; no rsp_rdy; the next command executes normally.
